// File: rtl/mem_stall_resp.sv
// rtl/mem_stall_resp.sv - multi-cycle single-word data-memory responder with stall/done handshake
//
// Purpose: serves one 16-bit word read or write per request, holds stall for
// LATENCY cycles, then pulses done for one cycle with the read result.
// Illegal requests (rd&wr, or odd address) are flagged on err and ignored.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (clears FSM, outputs and array)
//   addr      byte address of request (must be even; high bits alias)
//   data_in   write data
//   rd, wr    read / write request (exactly one may be high)
//   data_out  read data, valid with done and held until the next read completes
//   done      one-cycle completion pulse
//   stall     responder busy; requester must hold its pipeline
//   err       illegal request presented while idle

module mem_stall_resp #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  op_wr_q, op_wr_d;
  logic [15:0]           data_out_q, data_out_d;
  logic [15:0]           mem_q [DEPTH];

  // Completion strobe: asserted on the edge that moves the FSM into DONE.
  logic                  fin;
  logic                  fin_wr;
  logic [DEPTH_LOG2-1:0] fin_idx;
  logic [15:0]           fin_data;

  logic                  req_legal;
  logic                  req_illegal;
  logic [DEPTH_LOG2-1:0] in_idx;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];

  assign in_idx      = addr[DEPTH_LOG2:1];
  assign req_legal   = (rd ^ wr) & ~addr[0];
  assign req_illegal = (rd | wr) & ~req_legal;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    data_out_d = data_out_q;
    fin        = 1'b0;
    fin_wr     = op_wr_q;
    fin_idx    = idx_q;
    fin_data   = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_legal) begin
          idx_d   = in_idx;
          wdata_d = data_in;
          op_wr_d = wr;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            // No WAIT phase: complete straight from the live inputs,
            // since the latched copy is only visible next cycle.
            state_d  = ST_DONE;
            fin      = 1'b1;
            fin_wr   = wr;
            fin_idx  = in_idx;
            fin_data = data_in;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
          fin     = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fin && !fin_wr) begin
      data_out_d = mem_q[fin_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      op_wr_q    <= 1'b0;
      data_out_q <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      op_wr_q    <= op_wr_d;
      data_out_q <= data_out_d;
      if (fin && fin_wr) begin
        mem_q[fin_idx] <= fin_data;
      end
    end
  end

  assign data_out = data_out_q;
  assign done     = (state_q == ST_DONE);
  // stall rises in the accept cycle itself so the requester holds immediately.
  assign stall    = (state_q == ST_WAIT) | ((state_q == ST_IDLE) & req_legal);
  assign err      = (state_q == ST_IDLE) & req_illegal;

endmodule

// File: tb/tb_mem_stall_resp.sv
// tb/tb_mem_stall_resp.sv - directed self-checking bench for mem_stall_resp
module tb_mem_stall_resp;

  logic        clk;
  logic        rst;

  logic [15:0] addr4, data_in4, data_out4;
  logic        rd4, wr4, done4, stall4, err4;

  logic [15:0] addr1, data_in1, data_out1;
  logic        rd1, wr1, done1, stall1, err1;

  int errors;
  int checks;

  mem_stall_resp #(.DEPTH_LOG2(8), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .addr(addr4), .data_in(data_in4),
    .rd(rd4), .wr(wr4), .data_out(data_out4), .done(done4),
    .stall(stall4), .err(err4)
  );

  mem_stall_resp #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr1), .data_in(data_in1),
    .rd(rd1), .wr(wr1), .data_out(data_out1), .done(done1),
    .stall(stall1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit r, input bit w,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel) begin
      rd1 = r; wr1 = w; addr1 = a; data_in1 = d;
    end else begin
      rd4 = r; wr4 = w; addr4 = a; data_in4 = d;
    end
  endtask

  // One request on the selected instance; checks stall/done timing against lat.
  task automatic run_op(input bit sel, input bit is_wr,
                        input logic [15:0] a, input logic [15:0] d, input string tag);
    int lat;
    lat = sel ? 1 : 4;
    @(posedge clk); #1;
    drive(sel, !is_wr, is_wr, a, d);
    @(negedge clk);
    check({tag, "_c0_stall"}, {15'd0, sel ? stall1 : stall4}, 16'd1);
    check({tag, "_c0_done"},  {15'd0, sel ? done1  : done4},  16'd0);
    check({tag, "_c0_err"},   {15'd0, sel ? err1   : err4},   16'd0);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d_stall", tag, c), {15'd0, sel ? stall1 : stall4}, 16'd1);
      check($sformatf("%s_c%0d_done",  tag, c), {15'd0, sel ? done1  : done4},  16'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {15'd0, sel ? done1  : done4},  16'd1);
    check({tag, "_done_stall"}, {15'd0, sel ? stall1 : stall4}, 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_after_done"}, {15'd0, sel ? done1 : done4}, 16'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_data_out", data_out4, 16'h0000);
    check("rst_done", {15'd0, done4}, 16'd0);
    check("rst_stall", {15'd0, stall4}, 16'd0);
    check("rst_err", {15'd0, err4}, 16'd0);

    // 1: write then read back, data held after done
    run_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, "t1_wr");
    check("t1_wr_no_dout", data_out4, 16'h0000);
    run_op(1'b0, 1'b0, 16'h0010, 16'h0000, "t1_rd");
    check("t1_rd_data_held", data_out4, 16'hBEEF);
    run_op(1'b0, 1'b1, 16'h0040, 16'h7777, "t1_wr2");
    check("t1_wr_keeps_dout", data_out4, 16'hBEEF);

    // 2: rd&wr together is illegal
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'hFFFF);
    @(negedge clk);
    check("t2_err", {15'd0, err4}, 16'd1);
    check("t2_stall", {15'd0, stall4}, 16'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t2_no_done%0d", c), {15'd0, done4}, 16'd0);
      check($sformatf("t2_no_stall%0d", c), {15'd0, stall4}, 16'd0);
    end
    check("t2_dout_unchanged", data_out4, 16'hBEEF);
    run_op(1'b0, 1'b0, 16'h0020, 16'h0000, "t2_rd");
    check("t2_rd_data", data_out4, 16'h0000);

    // 3: odd address is illegal
    run_op(1'b0, 1'b0, 16'h0010, 16'h0000, "t3_pre");
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 16'h0031, 16'h0000);
    @(negedge clk);
    check("t3_err", {15'd0, err4}, 16'd1);
    check("t3_stall", {15'd0, stall4}, 16'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("t3_not_accepted", {15'd0, stall4}, 16'd0);
    check("t3_dout_unchanged", data_out4, 16'hBEEF);
    run_op(1'b0, 1'b0, 16'h0030, 16'h0000, "t3_rd");
    check("t3_rd_data", data_out4, 16'h0000);

    // 4: address aliasing above DEPTH_LOG2
    run_op(1'b0, 1'b1, 16'h0002, 16'h1234, "t4_wr");
    run_op(1'b0, 1'b0, 16'h0202, 16'h0000, "t4_rd");
    check("t4_alias_data", data_out4, 16'h1234);

    // 5: LATENCY=1 instance
    run_op(1'b1, 1'b1, 16'h0004, 16'hC0DE, "t5_wr");
    run_op(1'b1, 1'b0, 16'h0004, 16'h0000, "t5_rd");
    check("t5_rd_data", data_out1, 16'hC0DE);

    // 6: reset during an in-flight write
    run_op(1'b0, 1'b1, 16'h0008, 16'h5555, "t6_wr");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 16'h0008, 16'hAAAA);   // cycle 0
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);   // cycle 1
    @(posedge clk); #1;
    rst = 1'b1;                                    // cycle 2
    @(negedge clk);
    check("t6_stall_before_rst", {15'd0, stall4}, 16'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t6_no_done%0d", c), {15'd0, done4}, 16'd0);
      check($sformatf("t6_idle_stall%0d", c), {15'd0, stall4}, 16'd0);
      @(posedge clk); #1;
    end
    check("t6_rst_dout", data_out4, 16'h0000);
    run_op(1'b0, 1'b0, 16'h0010, 16'h0000, "t6_rd_other");
    check("t6_array_cleared_other", data_out4, 16'h0000);
    run_op(1'b0, 1'b0, 16'h0008, 16'h0000, "t6_rd");
    check("t6_rd_data", data_out4, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stall_resp.md
Name: mem_stall_resp

Overview:
Multi-cycle data-memory responder serving the pipeline's data-memory port (address, data, read/write enables in; data, done, stall out).
- Accepts one word read or write, holds stall for a fixed latency, then pulses done with read data.
- Gives the pipeline's dMemStall/iMemStall logic a real stalling target instead of single-cycle memory.
- Flags illegal requests on err so the top-level err OR can trap them.

Parameters:
DEPTH_LOG2, 8, log2 of number of 16-bit words in internal array (256 words)
LATENCY, 4, cycles from request acceptance to done pulse; legal range 1..15

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
addr  input  16  byte address of request; must be even
data_in  input  16  write data
rd  input  1  read request
wr  input  1  write request
data_out  output  16  read data; valid while done=1, held afterwards
done  output  1  one-cycle pulse: request complete
stall  output  1  responder busy; requester must hold pipeline
err  output  1  illegal request presented in IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, counter=0
  - data_out=16'h0000, done=0, stall=0, err=0
  - entire internal array cleared to 16'h0000
- Word index = addr[DEPTH_LOG2:1]. addr[15:DEPTH_LOG2+1] is ignored, so higher addresses alias onto the array.
- Legal request: exactly one of rd/wr high and addr[0]=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Legal request: latch addr, data_in, op; counter<=LATENCY-1; go to WAIT, or to DONE if LATENCY=1. stall=1 combinationally in this same cycle.
  - Illegal request (rd&wr, or addr[0]=1 with rd|wr): err=1 combinationally this cycle, stall=0, not accepted, array and data_out unchanged, stay IDLE.
  - No request: stall=0, err=0.
- WAIT:
  - stall=1; counter decrements each cycle.
  - When counter reaches 1, go to DONE on the next edge.
  - Inputs are ignored: the latched request is used, and err stays 0.
- Transition into DONE:
  - Latched write: committed to the array on this edge.
  - Latched read: array word loaded into data_out on this edge.
- DONE:
  - done=1, stall=0. Lasts exactly one cycle, then IDLE.
  - A request presented in the DONE cycle is not accepted; it must be re-presented (held) in the following IDLE cycle.
- Latency: request accepted at cycle 0 gives done=1 in cycle LATENCY; stall high for cycles 0..LATENCY-1.
- Back-to-back requests: minimum spacing LATENCY+1 cycles.
- data_out is never modified by writes; it holds the last read result until the next read completes.
- Read after write to the same word returns the new data (write committed before the read is accepted).
- rst in WAIT or DONE: immediate return to IDLE on that edge; a pending write is dropped, the array is cleared, and done is not pulsed.
- rst has priority over any concurrent request.

Test Plan:
1. LATENCY=4. Write addr=0x0010, data_in=0xBEEF; then read 0x0010 -> stall high cycles 0-3, done at cycle 4 each op; read data_out=0xBEEF, held after done falls.
2. rd=1 and wr=1 with addr=0x0020 in IDLE -> err=1 that cycle, stall=0, done never pulses; subsequent read of 0x0020 returns 0x0000.
3. Read addr=0x0031 -> err=1, not accepted. Then read addr=0x0030 -> done after 4 cycles, data_out=0x0000.
4. Write 0x1234 to 0x0002, then read 0x0202 (aliases, DEPTH_LOG2=8) -> data_out=0x1234.
5. Build with LATENCY=1. Write then read 0x0004 -> stall only in the accept cycle, done on the next cycle, read returns written value.
6. Write 0x5555 to 0x0008; assert rst during cycle 2 of a write of 0xAAAA to 0x0008 -> no done pulse, state IDLE; later read of 0x0008 returns 0x0000.
